clock_display_driver: RTL and testbench
=======================================

Name: clock_display_driver

Overview:
- Downstream stage of digital_clock. Converts its binary time or stopwatch fields into a time-multiplexed 6-digit, 7-segment display (HH MM SS).
- Each value is split into tens and ones digits. The driver scans the digits, blanks the leading zero of the hours, marks PM with a decimal point and blinks the display while the alarm rings.
- Runs on the fast board clock. All inputs are sampled into a frame snapshot so a display frame never mixes values from different seconds.

Parameters:
- SCAN_DIV, 1000, Clk_sys cycles each digit is lit (minimum 2).
- BLINK_FRAMES, 64, full 6-digit frames per alarm-blink half-period (minimum 1).
- SEG_ACTIVE_LOW, 1, 1 = common-anode board: seg_out, an_out and dp_out are driven low to light.

Ports:
- Clk_sys  input  1  board clock. Only clock in the block.
- reset_n_in  input  1  synchronous, active-low reset.
- seconds_in  input  6  clock seconds, 0..59.
- minutes_in  input  6  clock minutes, 0..59.
- hours_in  input  4  clock hours, 1..12.
- am_pm_in  input  1  0 = AM, 1 = PM.
- sw_seconds_in  input  6  stopwatch seconds.
- sw_minutes_in  input  6  stopwatch minutes.
- sw_hours_in  input  4  stopwatch hours, 0..15.
- alarm_ring_in  input  1  alarm active from digital_clock.
- mode_sel_in  input  1  0 = clock view, 1 = stopwatch view.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp_out  output  1  decimal point.
- an_out  output  6  digit enables. Bit 0 = seconds ones (rightmost), bit 5 = hours tens.

Behaviour:
- Reset (reset_n_in = 0 at a Clk_sys edge):
  - scan_cnt = 0, digit_idx = 0, blink_phase = 0, frame_cnt = 0.
  - Snapshot registers = 0; load_pending = 1.
  - an_out, seg_out and dp_out are all at their inactive level.
- Scan timing:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - At terminal count (TC), digit_idx advances 0→1→…→5→0.
- Snapshot:
  - All fields, mode_sel_in and alarm_ring_in are captured together.
  - Capture happens on the first cycle after reset deasserts (load_pending clears), and thereafter at every TC where digit_idx = 5 (frame boundary).
  - Input changes mid-frame have no effect until the next frame.
- Digit decode (from the snapshot and the selected view):
  - tens = value/10, ones = value%10. Pure combinational divide-by-constant on 6-bit values.
  - Any minutes/seconds value ≥ 60, or a clock-mode hours value of 0 or >12, shows both of that field's digits as "-" (segment g only).
  - Clock view: hours tens digit is blanked when 0 (for example " 3:58").
  - Stopwatch view: all digits are shown, including leading zeros. Hours 0..15 are shown as two digits.
- Decimal point:
  - Clock view: lit on digit 0 only when PM.
  - Stopwatch view: lit on digits 2 and 4 as field separators.
- Output registering:
  - an_out, seg_out and dp_out are registered.
  - They reflect digit_idx and the snapshot with 1-cycle latency.
  - Exactly one an_out bit is active at a time, except during blanking, when none is.
- Alarm blink:
  - frame_cnt counts frames while the snapshot alarm is 1. At BLINK_FRAMES it wraps and toggles blink_phase.
  - While blink_phase = 1 and the view is clock, all an_out bits are inactive.
  - When the snapshot alarm is 0: frame_cnt = 0 and blink_phase = 0. The display is steady on the next frame.
  - Stopwatch view ignores the alarm.
- Mode change: takes effect only at the frame boundary, never mid-frame.
- Reset mid-scan: outputs go inactive on the next edge. Scanning restarts at digit 0 with a fresh snapshot.

Decomposition:
- Shared package clock_pkg holds:
  - field widths: SEC_W = 6, MIN_W = 6, HR_W = 4;
  - NUM_DIGITS = 6;
  - the 7-segment encodings for 0–9, DASH and BLANK (active-high form);
  - the mode encodings MODE_CLOCK and MODE_SW.
- One sub-module: bin2bcd_2dig. Combinational, 6-bit binary in; tens, ones and out-of-range flag out. Instantiated once per field, three instances.

Test Plan (SCAN_DIV = 4, BLINK_FRAMES = 2, SEG_ACTIVE_LOW = 1):
- Hold reset_n_in = 0 for 3 cycles → an_out = 6'b111111, seg_out = 7'h7F, dp_out = 1. First lit digit appears 2 cycles after release: an_out = 6'b111110.
- Clock view, 3:58:07 PM → one frame shows 7, 0, 8, 5, 3 and a blank digit 5. dp_out is active only while digit 0 is lit. Each digit stays lit for 4 cycles.
- Change minutes_in 58→59 while digit_idx = 2 → the rest of the current frame still shows 58; the next frame shows 59.
- Stopwatch view, 0:00:42 → digits show 2, 4, 0, 0, 0, 0 with the hours tens 0 visible. dp_out is active on digits 2 and 4.
- alarm_ring_in = 1 in clock view → display alternates 2 frames lit and 2 frames fully dark. Dropping the alarm gives a steady display from the next frame.
- seconds_in = 60 and hours_in = 0 → the seconds digits and hours digits show "-" (seg_out = 7'b0111111). Minutes are shown normally.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the digital clock display path.
//   - field widths for seconds, minutes and hours
//   - number of display digits
//   - active-high 7-segment encodings ({g,f,e,d,c,b,a}) for 0-9, dash, blank
//   - view-select encodings and the frame snapshot record
package clock_pkg;

  localparam int SEC_W      = 6;
  localparam int MIN_W      = 6;
  localparam int HR_W       = 4;
  localparam int NUM_DIGITS = 6;

  // Segment bit order is {g,f,e,d,c,b,a}; 1 = segment lit.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SW    = 1'b1
  } mode_t;

  // Everything one display frame is built from, captured in a single cycle.
  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [MIN_W-1:0] min;
    logic [HR_W-1:0]  hr;
    logic             pm;
    logic [SEC_W-1:0] sw_sec;
    logic [MIN_W-1:0] sw_min;
    logic [HR_W-1:0]  sw_hr;
    logic             alarm;
    mode_t            mode;
  } snap_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// bin2bcd_2dig: combinational split of a 6-bit binary value into two decimal
// digits.
//   value  in  6  binary value 0..63
//   tens   out 4  value / 10
//   ones   out 4  value % 10
//   oor    out 1  value >= 60 (not a valid minutes/seconds value)
module bin2bcd_2dig (
  input  logic [5:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       oor
);

  assign tens = 4'(value / 6'd10);
  assign ones = 4'(value % 6'd10);
  assign oor  = (value >= 6'd60);

endmodule

// File: rtl/clock_display_driver.sv
// clock_display_driver: scans a 6-digit multiplexed 7-segment display (HH MM SS)
// from the clock or stopwatch time fields.
//   Clk_sys        in   board clock
//   reset_n_in     in   synchronous active-low reset
//   seconds_in/minutes_in/hours_in/am_pm_in   clock time
//   sw_seconds_in/sw_minutes_in/sw_hours_in   stopwatch time
//   alarm_ring_in  in   alarm ringing: blinks the clock view
//   mode_sel_in    in   0 = clock view, 1 = stopwatch view
//   seg_out        out  segments {g,f,e,d,c,b,a}
//   dp_out         out  decimal point
//   an_out         out  digit enables, bit 0 = seconds ones, bit 5 = hours tens
// All inputs are captured into a snapshot at each frame boundary so a frame
// never mixes values from different seconds. Outputs are registered and lag
// the scan position by one cycle.
module clock_display_driver
  import clock_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             Clk_sys,
  input  logic             reset_n_in,
  input  logic [SEC_W-1:0] seconds_in,
  input  logic [MIN_W-1:0] minutes_in,
  input  logic [HR_W-1:0]  hours_in,
  input  logic             am_pm_in,
  input  logic [SEC_W-1:0] sw_seconds_in,
  input  logic [MIN_W-1:0] sw_minutes_in,
  input  logic [HR_W-1:0]  sw_hours_in,
  input  logic             alarm_ring_in,
  input  logic             mode_sel_in,
  output logic [6:0]       seg_out,
  output logic             dp_out,
  output logic [NUM_DIGITS-1:0] an_out
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         digit_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;
  logic               load_pending;
  snap_t              snap;
  snap_t              snap_in;

  // Internal outputs are active-high; polarity is applied at the ports.
  logic [NUM_DIGITS-1:0] an_r;
  logic [6:0]            seg_r;
  logic                  dp_r;

  logic tc, frame_end, is_clock, dark;
  assign tc        = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_end = tc && (digit_idx == 3'd5);
  assign is_clock  = (snap.mode == MODE_CLOCK);
  // Gating by the snapshot alarm makes the display steady as soon as a frame
  // captures the alarm as off, whatever blink_phase still holds.
  assign dark      = is_clock && snap.alarm && blink_phase;

  assign snap_in = '{sec: seconds_in, min: minutes_in, hr: hours_in, pm: am_pm_in,
                     sw_sec: sw_seconds_in, sw_min: sw_minutes_in, sw_hr: sw_hours_in,
                     alarm: alarm_ring_in, mode: mode_t'(mode_sel_in)};

  // Field values for the selected view.
  logic [5:0] s_val, m_val, h_val;
  logic [3:0] s_tens, s_ones, m_tens, m_ones, h_tens, h_ones;
  logic       s_oor, m_oor, h_oor, h_bad;

  assign s_val = is_clock ? snap.sec : snap.sw_sec;
  assign m_val = is_clock ? snap.min : snap.sw_min;
  assign h_val = {2'b00, (is_clock ? snap.hr : snap.sw_hr)};

  bin2bcd_2dig u_sec (.value(s_val), .tens(s_tens), .ones(s_ones), .oor(s_oor));
  bin2bcd_2dig u_min (.value(m_val), .tens(m_tens), .ones(m_ones), .oor(m_oor));
  bin2bcd_2dig u_hr  (.value(h_val), .tens(h_tens), .ones(h_ones), .oor(h_oor));

  // Clock hours are only valid 1..12; stopwatch hours 0..15 always are.
  assign h_bad = h_oor || (is_clock && ((snap.hr == 4'd0) || (snap.hr > 4'd12)));

  logic [3:0] cur_digit;
  logic       cur_bad;
  logic [6:0] seg_next;
  logic       dp_next;

  always_comb begin
    cur_digit = 4'd0;
    cur_bad   = 1'b0;
    case (digit_idx)
      3'd0: begin cur_digit = s_ones; cur_bad = s_oor; end
      3'd1: begin cur_digit = s_tens; cur_bad = s_oor; end
      3'd2: begin cur_digit = m_ones; cur_bad = m_oor; end
      3'd3: begin cur_digit = m_tens; cur_bad = m_oor; end
      3'd4: begin cur_digit = h_ones; cur_bad = h_bad; end
      3'd5: begin cur_digit = h_tens; cur_bad = h_bad; end
      default: begin cur_digit = 4'd0; cur_bad = 1'b0; end
    endcase

    if (cur_bad)
      seg_next = SEG_DASH;
    else if (is_clock && (digit_idx == 3'd5) && (h_tens == 4'd0))
      seg_next = SEG_BLANK;   // leading-zero hour suppression
    else
      seg_next = seg_encode(cur_digit);

    if (is_clock)
      dp_next = (digit_idx == 3'd0) && snap.pm;
    else
      dp_next = (digit_idx == 3'd2) || (digit_idx == 3'd4);
  end

  always_ff @(posedge Clk_sys) begin
    if (!reset_n_in) begin
      scan_cnt     <= '0;
      digit_idx    <= 3'd0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      load_pending <= 1'b1;
      snap         <= '0;
      an_r         <= '0;
      seg_r        <= '0;
      dp_r         <= 1'b0;
    end else begin
      if (load_pending) begin
        // First cycle out of reset only captures; scanning starts next cycle.
        snap         <= snap_in;
        load_pending <= 1'b0;
      end else begin
        scan_cnt <= tc ? '0 : scan_cnt + SCAN_W'(1);
        if (tc)
          digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
        if (frame_end)
          snap <= snap_in;

        if (!snap.alarm) begin
          frame_cnt   <= '0;
          blink_phase <= 1'b0;
        end else if (frame_end) begin
          if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
          end
        end
      end

      if (load_pending || dark) begin
        an_r  <= '0;
        seg_r <= '0;
        dp_r  <= 1'b0;
      end else begin
        an_r  <= NUM_DIGITS'(1) << digit_idx;
        seg_r <= seg_next;
        dp_r  <= dp_next;
      end
    end
  end

  assign an_out  = an_r  ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
  assign seg_out = seg_r ^ {7{SEG_ACTIVE_LOW}};
  assign dp_out  = dp_r  ^ SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed testbench for clock_display_driver with SCAN_DIV = 4,
// BLINK_FRAMES = 2 and a common-anode (active-low) display.
module tb_clock_display_driver;

  logic       clk;
  logic       reset_n;
  logic [5:0] seconds, minutes, sw_seconds, sw_minutes;
  logic [3:0] hours, sw_hours;
  logic       am_pm, alarm, mode_sel;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [5:0] an_out;

  int n_assert = 0;
  int n_fail   = 0;

  clock_display_driver #(
    .SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .Clk_sys(clk), .reset_n_in(reset_n),
    .seconds_in(seconds), .minutes_in(minutes), .hours_in(hours), .am_pm_in(am_pm),
    .sw_seconds_in(sw_seconds), .sw_minutes_in(sw_minutes), .sw_hours_in(sw_hours),
    .alarm_ring_in(alarm), .mode_sel_in(mode_sel),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] S0 = 7'h3F, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66,
                         S5 = 7'h6D, S7 = 7'h07, S8 = 7'h7F, S9 = 7'h6F,
                         DA = 7'h40, BL = 7'h00;

  // Per-frame expectations, digit 5 first down to digit 0.
  localparam logic [41:0] F_035807 = {BL, S3, S5, S8, S0, S7};
  localparam logic [41:0] F_035907 = {BL, S3, S5, S9, S0, S7};
  localparam logic [41:0] F_SW42   = {S0, S0, S0, S0, S4, S2};
  localparam logic [41:0] F_DASH   = {DA, DA, S5, S9, DA, DA};
  localparam logic [5:0]  DP_PM    = 6'b000001;
  localparam logic [5:0]  DP_SW    = 6'b010100;

  task automatic chk(input string tag, input logic [5:0] ea,
                     input logic [6:0] es, input logic ed);
    n_assert++;
    assert (an_out === ea) else begin
      n_fail++;
      $error("FAIL %s an_out got %b expected %b", tag, an_out, ea);
    end
    n_assert++;
    assert (seg_out === es) else begin
      n_fail++;
      $error("FAIL %s seg_out got %b expected %b", tag, seg_out, es);
    end
    n_assert++;
    assert (dp_out === ed) else begin
      n_fail++;
      $error("FAIL %s dp_out got %b expected %b", tag, dp_out, ed);
    end
  endtask

  // Each digit lit for 4 cycles; sampled on the falling edge.
  task automatic run_digits(input string tag, input int lo, input int hi,
                            input logic [41:0] segs, input logic [5:0] dpm,
                            input bit dark);
    logic [5:0] ea;
    logic [6:0] es;
    for (int d = lo; d <= hi; d++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (dark) begin
          chk($sformatf("%s d%0d c%0d dark", tag, d, c), 6'h3F, 7'h7F, 1'b1);
        end else begin
          ea = ~(6'b000001 << d);
          es = ~segs[d*7 +: 7];
          chk($sformatf("%s d%0d c%0d", tag, d, c), ea, es, ~dpm[d]);
        end
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    seconds    = 6'd7;  minutes = 6'd58; hours = 4'd3; am_pm = 1'b1;
    sw_seconds = 6'd42; sw_minutes = 6'd0; sw_hours = 4'd0;
    alarm      = 1'b0;  mode_sel = 1'b0;

    // Reset held 3 cycles: everything inactive.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", 6'h3F, 7'h7F, 1'b1);

    // Release: first cycle is the snapshot load, display still dark.
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("load", 6'h3F, 7'h7F, 1'b1);

    // Clock view 3:58:07 PM
    run_digits("frameA", 0, 5, F_035807, DP_PM, 1'b0);

    // Minutes change while digit_idx = 2: current frame keeps 58.
    run_digits("frameB", 0, 1, F_035807, DP_PM, 1'b0);
    minutes = 6'd59;
    run_digits("frameB", 2, 5, F_035807, DP_PM, 1'b0);

    // Mode change requested now lands one frame later.
    mode_sel = 1'b1;
    run_digits("frameC", 0, 5, F_035907, DP_PM, 1'b0);

    // Stopwatch 0:00:42; request clock view with alarm for the next frame.
    mode_sel = 1'b0;
    alarm    = 1'b1;
    run_digits("sw", 0, 5, F_SW42, DP_SW, 1'b0);

    // Alarm blink: 2 lit, 2 dark, 2 lit, then dark.
    run_digits("blinkE", 0, 5, F_035907, DP_PM, 1'b0);
    run_digits("blinkF", 0, 5, F_035907, DP_PM, 1'b0);
    run_digits("blinkG", 0, 5, F_035907, DP_PM, 1'b1);
    run_digits("blinkH", 0, 5, F_035907, DP_PM, 1'b1);
    run_digits("blinkI", 0, 5, F_035907, DP_PM, 1'b0);
    run_digits("blinkJ", 0, 5, F_035907, DP_PM, 1'b0);
    alarm = 1'b0;
    run_digits("blinkK", 0, 5, F_035907, DP_PM, 1'b1);

    // Alarm dropped: steady from this frame. Queue out-of-range values.
    seconds = 6'd60;
    hours   = 4'd0;
    run_digits("steadyL", 0, 5, F_035907, DP_PM, 1'b0);

    // Seconds 60 and hours 0 show dashes, minutes normal; reset mid-frame.
    run_digits("dash", 0, 2, F_DASH, DP_PM, 1'b0);
    reset_n = 1'b0;
    seconds = 6'd7;
    hours   = 4'd3;
    @(posedge clk); @(negedge clk);
    chk("midreset", 6'h3F, 7'h7F, 1'b1);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("reload", 6'h3F, 7'h7F, 1'b1);
    run_digits("restart", 0, 5, F_035907, DP_PM, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
